// File: rtl/burst_backing_store.sv
// ============================================================================
// Module   : burst_backing_store
// Brief    : Behavioural backing store for the cache controller. Accepts one
//            request at a time. Writes are single-word with an optional byte
//            mask. Reads return a burst of 1..BURST_MAX words, critical word
//            first and wrapping within an aligned line, after a fixed
//            LATENCY.
// Macro    : BSTORE_BYTE_MASK_EN - when defined, adds the req_be port and
//            writes update only the enabled bytes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module burst_backing_store #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3,
    parameter int BURST_MAX   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [DATA_W-1:0]             req_data,
    input  logic                          req_type,
    input  logic [$clog2(BURST_MAX)-1:0]  req_len,
`ifdef BSTORE_BYTE_MASK_EN
    input  logic [DATA_W/8-1:0]           req_be,
`endif
    input  logic                          req_do,
    output logic                          req_ready,
    output logic [DATA_W-1:0]             O_data,
    output logic                          O_valid,
    output logic                          req_done
);

    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int LEN_W = $clog2(BURST_MAX);
    localparam int BE_W  = DATA_W / 8;
    // The wait counter only has to reach LATENCY-2 (the WAIT state spans
    // cycles 1..LATENCY-1 after accept).
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [IDX_W-1:0] LINE_MASK = IDX_W'(BURST_MAX - 1);

    // IDLE  : ready, waiting for a request.
    // WAIT  : latency cycles before the first result.
    // BURST : a cycle whose registered outputs carry a beat (read) or the
    //         completion pulse (write). A write spends exactly one cycle here
    //         and commits at the end of it.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_BURST = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_next_cnt;
    logic [LEN_W-1:0]   r_beat;
    logic [LEN_W-1:0]   w_next_beat;
    logic               w_emit;

    logic [IDX_W-1:0]   r_start;
    logic [DATA_W-1:0]  r_data;
    logic               r_is_wr;
    logic [LEN_W-1:0]   r_len;
    logic [BE_W-1:0]    r_be;

    logic               w_accept;
    logic [IDX_W-1:0]   w_start;
    logic               w_is_wr;
    logic [LEN_W-1:0]   w_len;
    logic [BE_W-1:0]    w_be;
    logic [IDX_W-1:0]   w_rd_idx;
    logic               w_next_valid;
    logic               w_next_done;
    logic [DATA_W-1:0]  w_merged;

    logic [DATA_W-1:0]  r_mem [DEPTH_WORDS];
    logic [DATA_W-1:0]  r_odata;
    logic               r_valid;
    logic               r_done;

    // Only the word-index bits of the address matter; the rest alias.
    logic [ADDR_W-1:0]  w_unused_addr;
    assign w_unused_addr = req_addr;

    assign w_accept = (r_state == S_IDLE) && req_do;

`ifdef BSTORE_BYTE_MASK_EN
    assign w_be = req_be;
`else
    assign w_be = '1;
`endif

    // With LATENCY==1 the first beat is scheduled on the accept edge itself,
    // so the request fields are taken straight from the inputs while idle.
    assign w_start = (r_state == S_IDLE) ? req_addr[OFF_W +: IDX_W] : r_start;
    assign w_is_wr = (r_state == S_IDLE) ? req_type : r_is_wr;
    assign w_len   = (r_state == S_IDLE) ? req_len  : r_len;

    // Beat k of a read wraps within the aligned line holding the start word.
    assign w_rd_idx = (w_start & ~LINE_MASK) |
                      ((w_start + IDX_W'(w_next_beat)) & LINE_MASK);

    assign w_next_valid = w_emit && !w_is_wr;
    assign w_next_done  = w_emit && (w_is_wr || (w_next_beat == w_len));

    // State register, latency counter and beat index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_beat  <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_beat  <= w_next_beat;
        end
    end

    // Next-state logic; w_emit flags entry into a beat/completion cycle.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_beat  = r_beat;
        w_emit       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_do) begin
                    w_next_cnt  = '0;
                    w_next_beat = '0;
                    if (LATENCY == 1) begin
                        w_next_state = S_BURST;
                        w_emit       = 1'b1;
                    end else begin
                        w_next_state = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_next_cnt = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(LATENCY - 2)) begin
                    w_next_state = S_BURST;
                    w_next_beat  = '0;
                    w_emit       = 1'b1;
                end
            end
            S_BURST: begin
                if (r_is_wr || (r_beat == r_len)) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_beat = r_beat + LEN_W'(1);
                    w_emit      = 1'b1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Capture the request fields on accept; they are frozen while busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_start <= '0;
            r_data  <= '0;
            r_is_wr <= 1'b0;
            r_len   <= '0;
            r_be    <= '0;
        end else if (w_accept) begin
            r_start <= req_addr[OFF_W +: IDX_W];
            r_data  <= req_data;
            r_is_wr <= req_type;
            r_len   <= req_len;
            r_be    <= w_be;
        end
    end

    // Registered read beat, beat strobe and completion pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_odata <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_valid <= w_next_valid;
            r_done  <= w_next_done;
            if (w_next_valid) begin
                r_odata <= r_mem[w_rd_idx];
            end
        end
    end

    // Merge the write data into the stored word under the byte enables.
    always_comb begin
        w_merged = r_mem[r_start];
        for (int b = 0; b < BE_W; b++) begin
            if (r_be[b]) begin
                w_merged[8*b +: 8] = r_data[8*b +: 8];
            end
        end
    end

    // Commit a write at the end of its completion cycle; storage is not reset.
    always_ff @(posedge clk) begin
        if ((r_state == S_BURST) && r_is_wr) begin
            r_mem[r_start] <= w_merged;
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign O_data    = r_odata;
    assign O_valid   = r_valid;
    assign req_done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_burst_backing_store.sv
`default_nettype none

module tb_burst_backing_store;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;
    localparam int LAT    = 3;
    localparam int BMAX   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        req_type;
    logic [1:0]  req_len;
    logic [3:0]  req_be;
    logic        req_do;
    logic        req_ready;
    logic [31:0] O_data;
    logic        O_valid;
    logic        req_done;

    burst_backing_store #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT),
        .BURST_MAX   (BMAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_type  (req_type),
        .req_len   (req_len),
`ifdef BSTORE_BYTE_MASK_EN
        .req_be    (req_be),
`endif
        .req_do    (req_do),
        .req_ready (req_ready),
        .O_data    (O_data),
        .O_valid   (O_valid),
        .req_done  (req_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             wr;
        logic [31:0]      addr;
        logic [31:0]      data;
        logic [1:0]       len;
        logic [3:0]       be;
        logic [3:0][31:0] exp;
    } op_t;

    localparam int NOPS = 18;
    op_t ops [NOPS];

    int checks = 0;
    int errors = 0;
    logic [31:0] sb_q [$];

`ifdef BSTORE_BYTE_MASK_EN
    localparam logic [31:0] MASK_EXP = 32'h12FF56FF;
`else
    localparam logic [31:0] MASK_EXP = 32'hFFFFFFFF;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic op_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                               input logic [1:0] len, input logic [3:0] be,
                               input logic [31:0] e0, input logic [31:0] e1,
                               input logic [31:0] e2, input logic [31:0] e3);
        op_t o;
        o.wr = wr; o.addr = addr; o.data = data; o.len = len; o.be = be;
        o.exp[0] = e0; o.exp[1] = e1; o.exp[2] = e2; o.exp[3] = e3;
        return o;
    endfunction

    // Scoreboard: every read beat is popped and compared against the queue.
    always @(negedge clk) begin : mon
        logic [31:0] e;
        if (reset === 1'b0 && O_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat_unexpected: got 0x%0h expected no beat", O_data);
            end else begin
                e = sb_q.pop_front();
                check("beat_data", {32'h0, O_data}, {32'h0, e});
            end
        end
    end

    // Issue one request from an idle negedge and check ready/valid/done on
    // every cycle until ready returns. Optionally pokes a stray request in
    // cycle 1 that must be ignored.
    task automatic run_op(input op_t op, input bit intrude);
        int w;
        int done_c;
        w = 0;
        while (req_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got req_ready=%b expected 1", req_ready);
            return;
        end
        req_addr = op.addr;
        req_data = op.data;
        req_type = op.wr;
        req_len  = op.len;
        req_be   = op.be;
        req_do   = 1'b1;
        if (!op.wr) begin
            for (int k = 0; k <= int'(op.len); k++) sb_q.push_back(op.exp[k]);
        end
        done_c = op.wr ? LAT : LAT + int'(op.len);
        @(posedge clk);
        #1 req_do = 1'b0;
        for (int c = 1; c <= done_c + 1; c++) begin
            @(negedge clk);
            check($sformatf("ctl_cycle%0d_ready_valid_done", c),
                  {61'h0, req_ready, O_valid, req_done},
                  {61'h0, (c > done_c), (!op.wr && c >= LAT && c <= done_c), (c == done_c)});
            if (intrude && c == 1) begin
                req_addr = 32'h2222_2222;
                req_data = 32'hDEAD_0001;
                req_type = 1'b1;
                req_len  = 2'd3;
                req_be   = 4'hF;
                req_do   = 1'b1;
            end
            if (intrude && c == 2) req_do = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        req_addr = '0;
        req_data = '0;
        req_type = 1'b0;
        req_len  = '0;
        req_be   = 4'hF;
        req_do   = 1'b0;

        ops[0]  = mk(1, 32'h3FC, 32'hAABBCCDD, 0, 4'hF, 0, 0, 0, 0);
        ops[1]  = mk(0, 32'h3FC, 0,            0, 4'hF, 32'hAABBCCDD, 0, 0, 0);
        ops[2]  = mk(1, 32'h200, 32'd1,        0, 4'hF, 0, 0, 0, 0);
        ops[3]  = mk(1, 32'h204, 32'd2,        0, 4'hF, 0, 0, 0, 0);
        ops[4]  = mk(1, 32'h208, 32'd3,        0, 4'hF, 0, 0, 0, 0);
        ops[5]  = mk(1, 32'h20C, 32'd4,        0, 4'hF, 0, 0, 0, 0);
        ops[6]  = mk(0, 32'h208, 0,            3, 4'hF, 3, 4, 1, 2);
        ops[7]  = mk(0, 32'h200, 0,            1, 4'hF, 1, 2, 0, 0);
        ops[8]  = mk(0, 32'h20C, 0,            1, 4'hF, 4, 1, 0, 0);
        ops[9]  = mk(0, 32'h204, 0,            2, 4'hF, 2, 3, 4, 0);
        ops[10] = mk(1, 32'h400, 32'h55,       0, 4'hF, 0, 0, 0, 0);
        ops[11] = mk(0, 32'h000, 0,            0, 4'hF, 32'h55, 0, 0, 0);
        ops[12] = mk(1, 32'h220, 32'h0BADF00D, 0, 4'hF, 0, 0, 0, 0);
        ops[13] = mk(1, 32'h000, 32'h11111111, 0, 4'hF, 0, 0, 0, 0);
        ops[14] = mk(0, 32'h000, 0,            0, 4'hF, 32'h11111111, 0, 0, 0);
        ops[15] = mk(1, 32'h300, 32'h12345678, 0, 4'hF, 0, 0, 0, 0);
        ops[16] = mk(1, 32'h300, 32'hFFFFFFFF, 0, 4'h5, 0, 0, 0, 0);
        ops[17] = mk(0, 32'h300, 0,            0, 4'hF, MASK_EXP, 0, 0, 0);

        repeat (2) @(negedge clk);
        check("reset_outputs", {28'h0, req_ready, O_valid, req_done, 1'b0, O_data},
              {28'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NOPS; i++) run_op(ops[i], 1'b0);

        // Stray request during a read: ignored, one done, word 0x220 intact.
        run_op(mk(0, 32'h208, 0, 3, 4'hF, 3, 4, 1, 2), 1'b1);
        run_op(mk(0, 32'h220, 0, 0, 4'hF, 32'h0BADF00D, 0, 0, 0), 1'b0);

        // Reset in cycle 2 of a write drops it.
        req_addr = 32'h000;
        req_data = 32'hDEADBEEF;
        req_type = 1'b1;
        req_len  = '0;
        req_be   = 4'hF;
        req_do   = 1'b1;
        @(posedge clk);
        #1 req_do = 1'b0;
        @(negedge clk);
        check("busy_before_reset", {63'h0, req_ready}, 64'h0);
        @(negedge clk);
        #1 reset = 1'b1;
        #1 check("reset_midwrite_outputs", {29'h0, req_ready, O_valid, req_done, O_data},
                 {29'h0, 1'b1, 1'b0, 1'b0, 32'h0});
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("no_done_after_reset", {62'h0, req_done, O_valid}, 64'h0);
        end
        run_op(mk(0, 32'h000, 0, 0, 4'hF, 32'h11111111, 0, 0, 0), 1'b0);

        check("scoreboard_empty", 64'(sb_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
